// File: rtl/uart_rx_if.sv
// Parallel-side bundle of the UART receiver: serial line in, recovered word and strobes out.
// The receiver binds the master modport; the consumer of the recovered words binds slave.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 serial_in;
  logic [DATA_BITS-1:0] received_data;
  logic                 data_valid;
  logic                 framing_error;
  logic                 parity_error;
  logic                 busy;

  modport master (
    input  serial_in,
    output received_data, data_valid, framing_error, parity_error, busy
  );

  modport slave (
    output serial_in,
    input  received_data, data_valid, framing_error, parity_error, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver (start, LSB-first data, optional parity, stop).
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int PARITY_ODD    = 0
) (
  input  logic      clk,
  input  logic      reset_n,
  uart_rx_if.master rx
);

  localparam int TICK_DIV = CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SAMP_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("uart_rx: CLK_FREQUENCY/(BAUD_RATE*OVERSAMPLE) must be >= 1");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be even and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx: DATA_BITS must be 5..9");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_rx: PARITY_ODD must be 0 or 1");
  end

  logic [2:0]           state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [SAMP_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 framing_error_q, framing_error_d;
  logic                 parity_error_q, parity_error_d;
  logic                 par_bad_q, par_bad_d;
  logic                 tick, samp_last, samp_half, line, fall;

  assign line      = sync2_q;
  assign fall      = prev_q & ~sync2_q;
  assign tick      = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign samp_last = (sample_cnt_q == SAMP_W'(OVERSAMPLE - 1));
  assign samp_half = (sample_cnt_q == SAMP_W'(OVERSAMPLE / 2 - 1));

  always_comb begin
    sync1_d         = rx.serial_in;
    sync2_d         = sync1_q;
    prev_d          = sync2_q;
    state_d         = state_q;
    tick_cnt_d      = tick ? '0 : tick_cnt_q + 1'b1;
    sample_cnt_d    = sample_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    rx_data_d       = rx_data_q;
    par_bad_d       = par_bad_q;
    data_valid_d    = 1'b0;
    framing_error_d = 1'b0;
    parity_error_d  = 1'b0;

    if (tick) sample_cnt_d = samp_last ? '0 : sample_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        // Phase the tick generator to the detected edge so sampling lands mid-bit.
        if (fall) begin
          state_d      = S_START;
          tick_cnt_d   = '0;
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
          par_bad_d    = 1'b0;
        end
      end
      S_START: begin
        if (tick && samp_half) begin
          sample_cnt_d = '0;
          state_d      = line ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && samp_last) begin
          shift_d      = {line, shift_q[DATA_BITS-1:1]};
          sample_cnt_d = '0;
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick && samp_last) begin
          par_bad_d    = line ^ (^shift_q) ^ 1'(PARITY_ODD);
          sample_cnt_d = '0;
          state_d      = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave at mid stop bit so a zero-gap next start edge is still caught.
        if (tick && samp_last) begin
          sample_cnt_d    = '0;
          state_d         = S_IDLE;
          rx_data_d       = shift_q;
          data_valid_d    = line & ~par_bad_q;
          framing_error_d = ~line;
          parity_error_d  = par_bad_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      prev_q          <= 1'b1;
      tick_cnt_q      <= '0;
      sample_cnt_q    <= '0;
      bit_cnt_q       <= '0;
      rx_data_q       <= '0;
      par_bad_q       <= 1'b0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      parity_error_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      prev_q          <= prev_d;
      tick_cnt_q      <= tick_cnt_d;
      sample_cnt_q    <= sample_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_data_q       <= rx_data_d;
      par_bad_q       <= par_bad_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
      parity_error_q  <= parity_error_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx.received_data = rx_data_q;
  assign rx.data_valid    = data_valid_q;
  assign rx.framing_error = framing_error_q;
`ifdef UART_RX_PARITY_EN
  assign rx.parity_error  = parity_error_q;
`else
  assign rx.parity_error  = 1'b0;
`endif
  assign rx.busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 32 MHz / 1 Mbaud / x16 (32 clk per bit).
module tb_uart_rx;

  localparam int BIT_CLK = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  uart_rx_if #(.DATA_BITS(8)) rx_if ();

  uart_rx #(
    .CLK_FREQUENCY(32_000_000),
    .BAUD_RATE    (1_000_000),
    .DATA_BITS    (8),
    .OVERSAMPLE   (16),
    .PARITY_ODD   (0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .rx     (rx_if)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the falling edge.
  int       cycle = 0;
  int       dv_cnt = 0, fe_cnt = 0, pe_cnt = 0;
  int       dv_cyc_last = 0, dv_cyc_prev = 0;
  logic [7:0] dv_data_last = '0, dv_data_prev = '0;
  logic     busy_at_dv = 1'b0;

  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (rx_if.data_valid === 1'b1) begin
      dv_cnt       <= dv_cnt + 1;
      dv_cyc_prev  <= dv_cyc_last;
      dv_cyc_last  <= cycle;
      dv_data_prev <= dv_data_last;
      dv_data_last <= rx_if.received_data;
      busy_at_dv   <= rx_if.busy;
    end
    if (rx_if.framing_error === 1'b1) fe_cnt <= fe_cnt + 1;
    if (rx_if.parity_error === 1'b1)  pe_cnt <= pe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_if.serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_if.serial_in = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_b);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_p(input logic [7:0] d, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par_b);
    send_bit(1'b1);
  endtask
`endif

  int dv0, fe0, pe0;
  logic [7:0] v;

  task automatic snap();
    @(negedge clk);
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
  endtask

  initial begin
    rx_if.serial_in = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_data",  32'(rx_if.received_data), 32'h0);
    chk("rst_dv",    32'(rx_if.data_valid),    32'h0);
    chk("rst_fe",    32'(rx_if.framing_error), 32'h0);
    chk("rst_pe",    32'(rx_if.parity_error),  32'h0);
    chk("rst_busy",  32'(rx_if.busy),          32'h0);
    reset_n = 1'b1;
    idle(20);

    // 1: clean frame 0xA5
    snap();
    v = 8'hA5;
    send_bit(1'b0);
    chk("t1_busy_mid", 32'(rx_if.busy), 32'h1);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit(1'b1);
    idle(20);
    chk("t1_dv_count", 32'(dv_cnt - dv0), 32'h1);
    chk("t1_data",     32'(dv_data_last), 32'hA5);
    chk("t1_fe_count", 32'(fe_cnt - fe0), 32'h0);
    chk("t1_pe_count", 32'(pe_cnt - pe0), 32'h0);
    chk("t1_busy_at_dv", 32'(busy_at_dv), 32'h0);
    chk("t1_busy_end", 32'(rx_if.busy), 32'h0);

    // 2: 8-clk glitch, then frame 0x3C
    snap();
    rx_if.serial_in = 1'b0;
    repeat (8) @(negedge clk);
    idle(40);
    chk("t2_glitch_busy", 32'(rx_if.busy),    32'h0);
    chk("t2_glitch_dv",   32'(dv_cnt - dv0),  32'h0);
    chk("t2_glitch_fe",   32'(fe_cnt - fe0),  32'h0);
    send_frame(8'h3C, 1'b1);
    idle(20);
    chk("t2_dv_count", 32'(dv_cnt - dv0), 32'h1);
    chk("t2_data",     32'(dv_data_last), 32'h3C);

    // 3: stop bit low, then line held low
    snap();
    send_frame(8'h81, 1'b0);
    chk("t3_fe_count", 32'(fe_cnt - fe0), 32'h1);
    chk("t3_dv_count", 32'(dv_cnt - dv0), 32'h0);
    chk("t3_data",     32'(rx_if.received_data), 32'h81);
    rx_if.serial_in = 1'b0;
    repeat (200) @(negedge clk);
    chk("t3_hold_fe",   32'(fe_cnt - fe0), 32'h1);
    chk("t3_hold_dv",   32'(dv_cnt - dv0), 32'h0);
    chk("t3_hold_busy", 32'(rx_if.busy),   32'h0);
    idle(40);

    // 4: back-to-back 0x00, 0xFF
    snap();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    chk("t4_dv_count", 32'(dv_cnt - dv0), 32'h2);
    chk("t4_spacing",  32'(dv_cyc_last - dv_cyc_prev), 32'd320);
    chk("t4_first",    32'(dv_data_prev), 32'h00);
    chk("t4_second",   32'(dv_data_last), 32'hFF);

    // 5: reset during data bit 4 of 0x55
    snap();
    v = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(v[i]);
    rx_if.serial_in = v[4];
    repeat (16) @(negedge clk);
    chk("t5_busy_before", 32'(rx_if.busy), 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("t5_rst_data", 32'(rx_if.received_data), 32'h0);
    chk("t5_rst_busy", 32'(rx_if.busy),          32'h0);
    chk("t5_rst_dv",   32'(rx_if.data_valid),    32'h0);
    chk("t5_rst_fe",   32'(rx_if.framing_error), 32'h0);
    chk("t5_rst_pe",   32'(rx_if.parity_error),  32'h0);
    idle(40);
    send_frame(8'h5A, 1'b1);
    idle(20);
    chk("t5_dv_count", 32'(dv_cnt - dv0), 32'h1);
    chk("t5_data",     32'(dv_data_last), 32'h5A);
    chk("t5_fe_count", 32'(fe_cnt - fe0), 32'h0);

`ifdef UART_RX_PARITY_EN
    // 6: even parity on 0x07 (three ones -> parity bit 1)
    snap();
    send_frame_p(8'h07, 1'b1);
    idle(20);
    chk("t6_good_dv", 32'(dv_cnt - dv0), 32'h1);
    chk("t6_good_pe", 32'(pe_cnt - pe0), 32'h0);
    snap();
    send_frame_p(8'h07, 1'b0);
    idle(20);
    chk("t6_bad_pe", 32'(pe_cnt - pe0), 32'h1);
    chk("t6_bad_dv", 32'(dv_cnt - dv0), 32'h0);
`else
    chk("t6_pe_never", 32'(pe_cnt), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
